// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a valid/ready
// request channel, buffers in-order responses and presents one instruction at a
// time to decode/control. Redirects restart fetch and discard stale responses.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);

    localparam int unsigned     PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]     NOP       = 32'h0000_0013;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  rsp_pc_q;
    logic [CNT_W-1:0] out_q;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;

    logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];
    logic [31:0]      data_mem [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             req_fire;
    logic             rsp_drop;
    logic [CNT_W:0]   occupancy;
    logic [XLEN-1:0]  redirect_target;

    // Present the FIFO head, or a NOP at PC 0 when nothing is buffered.
    always_comb begin
        inst_valid = (count_q != '0);
        inst_data  = NOP;
        inst_pc    = '0;
        if (inst_valid) begin
            inst_data = data_mem[rd_ptr_q];
            inst_pc   = pc_mem[rd_ptr_q];
        end
        opcode = inst_data[6:0];
    end

    // Request gating and response steering. Outstanding plus buffered entries
    // (net of this cycle's pop) must leave room for the new fetch's response.
    always_comb begin
        pop             = inst_valid && inst_ready;
        occupancy       = {1'b0, out_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
        imem_req_valid  = !rst && !redirect_valid && (occupancy < DEPTH_LIM);
        imem_req_addr   = pc_q;
        req_fire        = imem_req_valid && imem_req_ready;
        rsp_drop        = (drop_q != '0);
        push            = imem_rsp_valid && !rsp_drop && !redirect_valid;
        redirect_target = redirect_pc & ~XLEN'(3);
    end

    // PC, in-flight bookkeeping and FIFO pointers; redirect flushes everything
    // and marks all still-outstanding responses (minus one arriving now) for drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            out_q <= out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                pc_q     <= redirect_target;
                rsp_pc_q <= redirect_target;
                drop_q   <= out_q - CNT_W'(imem_rsp_valid);
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + XLEN'(4);
                end
                if (imem_rsp_valid && rsp_drop) begin
                    drop_q <= drop_q - CNT_W'(1);
                end
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + XLEN'(4);
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Instruction buffer storage; contents only matter while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
            data_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with variable latency and
// a scoreboard of expected {pc, data} pushed on request acceptance.
module tb_instr_fetch_unit;

    localparam int unsigned XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;

    instr_fetch_unit #(
        .XLEN(XLEN),
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .opcode(opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        int unsigned lat;
    } redir_vec_t;

    mreq_t       mq[$];
    inst_t       sb[$];
    int unsigned mem_lat;
    int unsigned cyc;
    logic [31:0] model_pc;
    int          n_vec;
    int          n_err;

    logic        last_fire;
    logic [31:0] last_fire_addr;
    logic        last_pop;
    logic [31:0] last_pop_pc;
    logic        last_inst_valid;
    logic        last_req_valid;
    logic [31:0] last_head_pc;
    logic [31:0] last_head_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample at negedge, update scoreboard, advance memory model.
    task automatic cycle();
        inst_t e;
        mreq_t m;
        @(negedge clk);
        last_fire       = imem_req_valid && imem_req_ready;
        last_fire_addr  = imem_req_addr;
        last_pop        = inst_valid && inst_ready;
        last_pop_pc     = inst_pc;
        last_inst_valid = inst_valid;
        last_req_valid  = imem_req_valid;
        last_head_pc    = inst_pc;
        last_head_data  = inst_data;
        if (!rst) begin
            if (inst_valid) begin
                check("valid_has_expected_entry", 32'(sb.size() != 0), 32'd1);
            end
            if (last_pop && sb.size() != 0) begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
                check("opcode", {25'b0, opcode}, {25'b0, e.data[6:0]});
            end
            if (last_fire) begin
                check("req_addr", imem_req_addr, model_pc);
                sb.push_back('{pc: model_pc, data: mem_word(model_pc)});
                mq.push_back('{addr: model_pc, due: cyc + mem_lat});
                model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) begin
                check("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
                sb.delete();
                model_pc = redirect_pc & ~32'd3;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
            sb.delete();
            model_pc       = RESET_PC;
            imem_rsp_valid = 1'b0;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(m.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_fire(input string name, input logic [31:0] exp_addr);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_fire) begin
                check(name, last_fire_addr, exp_addr);
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: no request within 30 cycles, expected addr %h", name, exp_addr);
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_pop) begin
                check(name, last_pop_pc, exp_pc);
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: no instruction within 30 cycles, expected pc %h", name, exp_pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst_data"}, inst_data, 32'h0000_0013);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_opcode"}, {25'b0, opcode}, 32'h13);
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        repeat (8) cycle();
        check("drained_valid", 32'(last_inst_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t rv [4];
        int         fv;
        int         pops;
        int         fires;
        int         changes;
        logic [31:0] head_pc0;
        logic [31:0] head_data0;

        rv[0] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100, lat: 1};
        rv[1] = '{rpc: 32'h0000_0200, exp_addr: 32'h0000_0200, lat: 2};
        rv[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC, lat: 3};
        rv[3] = '{rpc: 32'h0000_0ABD, exp_addr: 32'h0000_0ABC, lat: 1};

        n_vec = 0;
        n_err = 0;
        cyc = 0;
        mem_lat = 1;
        model_pc = RESET_PC;
        rst = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b1;

        // Reset values
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("release_req_valid", 32'(imem_req_valid), 32'd1);
        check("release_req_addr", imem_req_addr, RESET_PC);

        // Streaming with L=1: first valid two cycles after release, then one per cycle
        fv = -1;
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_inst_valid && fv < 0) fv = i;
            if (last_pop) pops++;
        end
        check("first_valid_cycle", 32'(fv), 32'd2);
        check("stream_pops", 32'(pops), 32'd18);

        // Downstream stall: bounded requests, head held, order kept afterwards
        inst_ready = 1'b0;
        fires = 0;
        changes = 0;
        head_pc0 = 32'h0;
        head_data0 = 32'h0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_fire) fires++;
            if (i == 0) begin
                head_pc0 = last_head_pc;
                head_data0 = last_head_data;
            end else if (last_head_pc !== head_pc0 || last_head_data !== head_data0) begin
                changes++;
            end
        end
        check("stall_fires_within_depth", 32'(fires <= int'(FIFO_DEPTH)), 32'd1);
        check("stall_req_valid_low", 32'(last_req_valid), 32'd0);
        check("stall_inst_valid", 32'(last_inst_valid), 32'd1);
        check("stall_head_changes", 32'(changes), 32'd0);
        inst_ready = 1'b1;
        wait_pop("stall_release_pc", head_pc0);
        repeat (10) cycle();

        // Table: redirect target alignment and restart, varying latency
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_lat = rv[i].lat;
            redirect_to(rv[i].rpc);
            wait_fire("redir_req_addr", rv[i].exp_addr);
            wait_pop("redir_inst_pc", rv[i].exp_addr);
            repeat (6) cycle();
        end

        // Two fetches in flight with L=3, then redirect: both discarded
        drain();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        redirect_to(32'h0000_0010);
        cycle();
        check("inflight_fire0", 32'(last_fire), 32'd1);
        check("inflight_addr0", last_fire_addr, 32'h0000_0010);
        cycle();
        check("inflight_fire1", 32'(last_fire), 32'd1);
        check("inflight_addr1", last_fire_addr, 32'h0000_0014);
        redirect_to(32'h0000_0200);
        wait_fire("inflight_next_addr", 32'h0000_0200);
        wait_pop("inflight_next_pc", 32'h0000_0200);
        repeat (4) cycle();

        // Redirect coincident with a response, one more still in flight
        drain();
        mem_lat = 2;
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        check("coincident_rsp_present", 32'(imem_rsp_valid), 32'd1);
        redirect_to(32'h0000_0300);
        wait_pop("coincident_next_pc", 32'h0000_0300);
        repeat (6) cycle();

        // Randomised traffic with occasional redirects
        for (int i = 0; i < 300; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect_to($urandom);
            end else begin
                cycle();
            end
        end
        drain();

        // Reset mid-stream with the buffer full
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat = 1;
        repeat (6) cycle();
        check("full_before_reset", 32'(last_inst_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        cycle();
        cycle();
        rst = 1'b0;
        inst_ready = 1'b1;
        #1;
        check("rerelease_req_valid", 32'(imem_req_valid), 32'd1);
        check("rerelease_req_addr", imem_req_addr, RESET_PC);
        wait_pop("rerelease_first_pc", RESET_PC);
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
